nn_weight_loader: RTL and testbench
===================================

Name: nn_weight_loader

Overview:
- Drives the weight shift chain of simple_nn. It is the transmitter end of the shift_i / weights_i / weights_o chain interface.
- Accepts 32-bit weight words from a host over a valid/ready stream and shifts exactly NumWeights words into the chain, one shift pulse per word.
- Optional verify pass: recirculates the whole chain once through its tail (weights_o of simple_nn) and checks a sum checksum, leaving chain contents unchanged.

Parameters:
- NumWeights, 21, chain depth in 32-bit words; 2x3 + 3x3 + 3x2 for the default network; must be >= 1.
- CountW, $clog2(NumWeights+1), width of the word counter.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle start; honoured only in IDLE.
- verify_en_i  in  1  sampled with start_i; 1 = run verify pass after load.
- wvalid_i  in  1  host weight word valid.
- wready_o  out  1  loader ready for a host word.
- wdata_i  in  32  host weight word.
- shift_o  out  1  to simple_nn shift_i; chain advances on each edge where high.
- weights_o  out  32  to simple_nn weights_i; head word of the chain.
- weights_i  in  32  from simple_nn weights_o; chain tail word.
- busy_o  out  1  high in LOAD or VERIFY.
- done_o  out  1  high from operation end until next accepted start_i.
- error_o  out  1  checksum mismatch; valid while done_o is high.
- count_o  out  CountW  words shifted in the current phase.

Behaviour:
- Reset (reset_i low, async): state IDLE. wready_o, shift_o, busy_o, done_o, error_o = 0. weights_o = 0, count_o = 0, checksum = 0, verify flag = 0.
- Reset mid-operation aborts immediately. Chain contents are then undefined; the host must reload.
- FSM states: IDLE, LOAD, DRAIN, VERIFY, DONE.
- IDLE to LOAD on start_i:
  - clears count_o, checksum and error_o; drops done_o; latches verify_en_i.
- LOAD:
  - wready_o = 1 while count_o < NumWeights.
  - Word accepted when wvalid_i & wready_o.
  - On the accepting edge: weights_o register <= wdata_i; shift_o register <= 1 (high in the following cycle only); count_o += 1; checksum += wdata_i (mod 2^32).
  - Cycle with no accept: shift_o = 0; weights_o holds its value.
  - Back-to-back accepts give one shift pulse per cycle. Latency from accept to shift_o is 1 cycle.
- LOAD exit: on the edge accepting word NumWeights, go to DRAIN. wready_o drops in the cycle the final shift_o is high; no further words are accepted.
- DRAIN: one cycle, in which the final shift executes.
  - Next state VERIFY if the verify flag is set; count_o <= 0; verify sum <= 0.
  - Otherwise next state DONE.
- VERIFY:
  - shift_o = 1 for exactly NumWeights consecutive cycles, driven combinationally from state.
  - weights_o = weights_i, combinational mux, so each tail word re-enters the head and the chain is unchanged after NumWeights shifts.
  - Each cycle: verify sum += weights_i; count_o += 1.
  - At count_o = NumWeights - 1, go to DONE.
- DONE:
  - busy_o = 0, done_o = 1, shift_o = 0, wready_o = 0.
  - error_o = 1 if the verify pass ran and verify sum != checksum; otherwise 0.
  - Remains until start_i, then behaves as in IDLE.
- start_i in LOAD, DRAIN or VERIFY is ignored.
- wvalid_i outside LOAD is ignored (never acknowledged).
- busy_o = 1 in LOAD, DRAIN and VERIFY.
- Checksum and verify sum are 32-bit with wrap-around; overflow is not an error.
- NumWeights = 1: load of a single word, and a single verify cycle, must work.

Test Plan:
- Load without verify: start_i with verify_en_i = 0, host streams 1..21 back-to-back -> 21 consecutive shift_o cycles carrying weights_o = 1..21; done_o = 1 two cycles after the last accept; error_o = 0; chain model holds 21 at head and 1 at tail.
- Load with verify: as above with verify_en_i = 1 and a behavioural 21-deep chain model -> 21 more shift cycles with weights_o equal to the tail (1..21 in order); chain model unchanged afterwards; error_o = 0; count_o = 21 during DONE.
- Corrupted chain: model flips bit 0 of one stored word before verify -> error_o = 1 with done_o.
- Bursty host: wvalid_i toggled 1,0,0,1,... with values 0xFFFFFFFF (checksum wrap) -> shift_o pulses only after accepts; exactly 21 pulses total; a 22nd wvalid_i is never acknowledged; error_o = 0.
- Reset mid-load: reset_i low after word 7 -> all outputs 0 asynchronously; a following start_i plus 21 words loads cleanly.
- start_i pulsed during LOAD and VERIFY -> no effect on count_o, state or shift count.

Source files
------------

// File: rtl/nn_weight_loader.sv
// rtl/nn_weight_loader.sv - transmitter for the simple_nn weight shift chain
// Streams NumWeights host words into the chain, with an optional recirculating checksum pass.
module nn_weight_loader #(
  parameter int NumWeights = 21,
  parameter int CountW     = $clog2(NumWeights + 1)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              verify_en_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [31:0]       wdata_i,
  output logic              shift_o,
  output logic [31:0]       weights_o,
  input  logic [31:0]       weights_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CountW-1:0] count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam logic [CountW-1:0] LastCount = CountW'(NumWeights - 1);
  localparam logic [CountW-1:0] FullCount = CountW'(NumWeights);

  state_t              state_q, state_d;
  logic [CountW-1:0]   count_q;
  logic [31:0]         csum_q;
  logic [31:0]         vsum_q;
  logic [31:0]         weights_q;
  logic                shift_q;
  logic                verify_q;
  logic                accept;

  always_comb begin
    state_d  = state_q;
    wready_o = (state_q == S_LOAD) && (count_q < FullCount);
    accept   = wvalid_i && wready_o;
    case (state_q)
      S_IDLE, S_DONE: if (start_i) state_d = S_LOAD;
      S_LOAD:         if (accept && (count_q == LastCount)) state_d = S_DRAIN;
      S_DRAIN:        state_d = verify_q ? S_VERIFY : S_DONE;
      S_VERIFY:       if (count_q == LastCount) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // During verify the tail feeds straight back to the head, so the chain comes out unchanged.
  assign shift_o   = (state_q == S_VERIFY) || shift_q;
  assign weights_o = (state_q == S_VERIFY) ? weights_i : weights_q;
  assign busy_o    = (state_q == S_LOAD) || (state_q == S_DRAIN) || (state_q == S_VERIFY);
  assign done_o    = (state_q == S_DONE);
  assign error_o   = done_o && verify_q && (vsum_q != csum_q);
  assign count_o   = count_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      csum_q    <= '0;
      vsum_q    <= '0;
      weights_q <= '0;
      shift_q   <= 1'b0;
      verify_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            count_q  <= '0;
            csum_q   <= '0;
            verify_q <= verify_en_i;
          end
        end
        S_LOAD: begin
          if (accept) begin
            weights_q <= wdata_i;
            shift_q   <= 1'b1;
            count_q   <= count_q + CountW'(1);
            csum_q    <= csum_q + wdata_i;
          end
        end
        S_DRAIN: begin
          if (verify_q) begin
            count_q <= '0;
            vsum_q  <= '0;
          end
        end
        S_VERIFY: begin
          vsum_q  <= vsum_q + weights_i;
          count_q <= count_q + CountW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_weight_loader.sv
// tb/tb_nn_weight_loader.sv - self-checking bench for nn_weight_loader
// Drives host words and models the simple_nn chain as a plain shift array.
module tb_nn_weight_loader;
  localparam int N  = 21;
  localparam int CW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic          verify_en_i = 1'b0;
  logic          wvalid_i = 1'b0;
  logic [31:0]   wdata_i = '0;
  logic          wready_o, shift_o, busy_o, done_o, error_o;
  logic [31:0]   weights_o, weights_i;
  logic [CW-1:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] chain [N];
  logic [31:0] shifted [$];
  int          nshift = 0;
  bit          corrupt_on = 1'b0;
  int          corrupt_idx = 0;

  always #5 clk_i = ~clk_i;

  nn_weight_loader #(.NumWeights(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .verify_en_i(verify_en_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o), .wdata_i(wdata_i),
    .shift_o(shift_o), .weights_o(weights_o), .weights_i(weights_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .count_o(count_o)
  );

  assign weights_i = chain[N-1];

  // Behavioural chain: head is index 0, tail is index N-1; optional bit flip after the load.
  always @(posedge clk_i) begin : chain_model
    logic [31:0] tmp [N];
    if (start_i && !busy_o) nshift <= 0;
    else if (shift_o) nshift <= nshift + 1;
    if (shift_o) begin
      shifted.push_back(weights_o);
      tmp[0] = weights_o;
      for (int i = 1; i < N; i++) tmp[i] = chain[i-1];
      if (corrupt_on && nshift == N - 1) tmp[corrupt_idx][0] = ~tmp[corrupt_idx][0];
      chain <= tmp;
    end
  end

  task automatic do_start(input bit v);
    @(negedge clk_i);
    start_i = 1'b1;
    verify_en_i = v;
    @(negedge clk_i);
    start_i = 1'b0;
    verify_en_i = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] ws[$], input int stop_after, input int start_at);
    int i = 0;
    int cyc = 0;
    while (i < stop_after && cyc < 1000) begin
      wvalid_i = 1'b1;
      wdata_i  = ws[i];
      start_i  = (cyc == start_at);
      if (wready_o) i++;
      cyc++;
      @(negedge clk_i);
    end
    wvalid_i = 1'b0;
    start_i  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int cyc = 0;
    while (!done_o && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
    end
    ok = done_o;
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    #12;
    n_cmp++;
    if ({wready_o, shift_o, busy_o, done_o, error_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 00000", {wready_o, shift_o, busy_o, done_o, error_o});
    end
    n_cmp++;
    if (weights_o !== 32'h0 || count_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got weights %h count %0d want 0 0", weights_o, count_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    shifted.delete();
    wvalid_i = 1'b1;
    wdata_i = $urandom;
    repeat (4) @(negedge clk_i);
    n_cmp++;
    if (wready_o !== 1'b0 || shifted.size() != 0) begin
      n_bad++;
      $display("FAIL idle_wvalid: got wready %b shifts %0d want 0 0", wready_o, shifted.size());
    end
    wvalid_i = 1'b0;
  endtask

  task automatic test_load_no_verify();
    logic [31:0] ws[$];
    bit ok;
    int bad = 0;
    for (int i = 1; i <= N; i++) ws.push_back(32'(i));
    shifted.delete();
    do_start(1'b0);
    load_words(ws, N, -1);
    n_cmp++;
    if (shift_o !== 1'b1 || done_o !== 1'b0 || wready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_cycle: got shift %b done %b wready %b want 1 0 0", shift_o, done_o, wready_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b1 || shift_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL done_timing: got done %b shift %b busy %b want 1 0 0", done_o, shift_o, busy_o);
    end
    for (int i = 0; i < N; i++) if (shifted.size() != N || shifted[i] !== ws[i]) bad++;
    n_cmp++;
    if (bad != 0 || shifted.size() != N) begin
      n_bad++;
      $display("FAIL load_words: got %0d shifts %0d bad want %0d shifts 0 bad", shifted.size(), bad, N);
    end
    n_cmp++;
    if (chain[0] !== 32'd21 || chain[N-1] !== 32'd1) begin
      n_bad++;
      $display("FAIL chain_ends: got head %0d tail %0d want 21 1", chain[0], chain[N-1]);
    end
    n_cmp++;
    if (error_o !== 1'b0 || count_o !== CW'(N)) begin
      n_bad++;
      $display("FAIL load_status: got error %b count %0d want 0 %0d", error_o, count_o, N);
    end
    wait_done(ok);
  endtask

  task automatic test_load_verify(input bit corrupt);
    logic [31:0] ws[$];
    bit ok;
    int bad = 0;
    for (int i = 0; i < N; i++) ws.push_back($urandom);
    shifted.delete();
    corrupt_on = corrupt;
    corrupt_idx = $urandom_range(0, N - 1);
    do_start(1'b1);
    load_words(ws, N, -1);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL verify_done_c%0d: got done %b want 1", corrupt, done_o);
    end
    n_cmp++;
    if (shifted.size() != 2 * N) begin
      n_bad++;
      $display("FAIL verify_shifts_c%0d: got %0d want %0d", corrupt, shifted.size(), 2 * N);
    end
    n_cmp++;
    if (error_o !== corrupt || count_o !== CW'(N)) begin
      n_bad++;
      $display("FAIL verify_status_c%0d: got error %b count %0d want %b %0d", corrupt, error_o, count_o, corrupt, N);
    end
    if (!corrupt) begin
      for (int i = 0; i < N; i++) begin
        if (shifted.size() != 2 * N || shifted[N+i] !== ws[i]) bad++;
        if (chain[i] !== ws[N-1-i]) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL verify_recirc: got %0d bad words want 0", bad);
      end
    end
    corrupt_on = 1'b0;
  endtask

  task automatic test_bursty();
    bit ok;
    bit acc_prev = 1'b0;
    int acc = 0;
    int bad = 0;
    int cyc = 0;
    int ones = 0;
    shifted.delete();
    do_start(1'b1);
    while (!done_o && cyc < 400) begin
      if ((acc < N || acc_prev) && shift_o !== acc_prev) bad++;
      wvalid_i = (acc >= N) ? 1'b1 : (cyc % 3 == 0);
      wdata_i  = 32'hFFFF_FFFF;
      acc_prev = wvalid_i && wready_o;
      if (acc_prev) acc++;
      cyc++;
      @(negedge clk_i);
    end
    repeat (3) begin
      if (wready_o) acc++;
      @(negedge clk_i);
    end
    wvalid_i = 1'b0;
    wait_done(ok);
    foreach (shifted[i]) if (shifted[i] !== 32'hFFFF_FFFF) ones++;
    n_cmp++;
    if (bad != 0 || acc != N) begin
      n_bad++;
      $display("FAIL bursty_accepts: got %0d stray pulses %0d accepts want 0 %0d", bad, acc, N);
    end
    n_cmp++;
    if (!ok || error_o !== 1'b0 || shifted.size() != 2 * N || ones != 0) begin
      n_bad++;
      $display("FAIL bursty_wrap: got done %b error %b shifts %0d odd %0d want 1 0 %0d 0", done_o, error_o, shifted.size(), ones, 2 * N);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] ws[$];
    bit ok;
    int bad = 0;
    for (int i = 0; i < N; i++) ws.push_back($urandom);
    do_start(1'b0);
    load_words(ws, 7, -1);
    #2 reset_i = 1'b0;
    #1;
    n_cmp++;
    if ({wready_o, shift_o, busy_o, done_o, error_o} !== 5'b0 || weights_o !== 32'h0 || count_o !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got flags %b weights %h count %0d want 0", {wready_o, shift_o, busy_o, done_o, error_o}, weights_o, count_o);
    end
    @(negedge clk_i);
    reset_i = 1'b1;
    ws.delete();
    for (int i = 0; i < N; i++) ws.push_back($urandom);
    shifted.delete();
    do_start(1'b0);
    load_words(ws, N, -1);
    wait_done(ok);
    for (int i = 0; i < N; i++) if (shifted.size() != N || shifted[i] !== ws[i] || chain[i] !== ws[N-1-i]) bad++;
    n_cmp++;
    if (!ok || bad != 0 || error_o !== 1'b0 || count_o !== CW'(N)) begin
      n_bad++;
      $display("FAIL reload_after_reset: got done %b bad %0d error %b count %0d want 1 0 0 %0d", ok, bad, error_o, count_o, N);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] ws[$];
    bit ok;
    int bad = 0;
    for (int i = 0; i < N; i++) ws.push_back($urandom);
    shifted.delete();
    do_start(1'b1);
    load_words(ws, N, 5);
    repeat (4) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_done(ok);
    for (int i = 0; i < N; i++) if (chain[i] !== ws[N-1-i]) bad++;
    n_cmp++;
    if (!ok || shifted.size() != 2 * N || count_o !== CW'(N) || error_o !== 1'b0 || bad != 0) begin
      n_bad++;
      $display("FAIL start_ignored: got done %b shifts %0d count %0d error %b bad %0d want 1 %0d %0d 0 0", ok, shifted.size(), count_o, error_o, bad, 2 * N, N);
    end
  endtask

  initial begin
    test_reset();
    test_load_no_verify();
    test_load_verify(1'b0);
    test_load_verify(1'b1);
    test_bursty();
    test_reset_mid_load();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
